// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int unsigned REQ_0      = 0;
  localparam int unsigned REQ_1      = 1;
  localparam logic [3:0]  WR_NONE    = 4'b0000;
  localparam int unsigned PERF_CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with the last-grant pointer.
// The pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_core,
  input  logic       rst_core_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       winner
);

  logic last_grant_q;

  // Pick the requester not served last time when both ask.
  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    if (req[REQ_0] && req[REQ_1]) begin
      winner = ~last_grant_q;
    end else if (req[REQ_1]) begin
      winner = 1'b1;
    end
    if (|req) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

  // Remember who won, but only when a grant is actually taken.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      last_grant_q <= 1'b1;
    end else if (grant_en && (|req)) begin
      last_grant_q <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-ported synchronous-read SRAM.
// Optional saturating performance counters are enabled with MEM_ARB_PERF_CNT_EN.
//
// state | meaning
// IDLE  | sample requests, latch winner's command
// ISSUE | one-cycle memory strobe from the latched command
// WAIT  | count down the read latency, capture read data at zero
// RESP  | one-cycle Ack to the granted requester
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  Clk_Core,
  input  logic                  Rst_Core_N,
  input  logic                  Req_0,
  input  logic [AWIDTH-1:0]     Addr_0,
  input  logic [3:0]            Wr_Ctrl_0,
  input  logic [DWIDTH-1:0]     Wdata_0,
  output logic                  Ack_0,
  output logic [DWIDTH-1:0]     Rdata_0,
  input  logic                  Req_1,
  input  logic [AWIDTH-1:0]     Addr_1,
  input  logic [3:0]            Wr_Ctrl_1,
  input  logic [DWIDTH-1:0]     Wdata_1,
  output logic                  Ack_1,
  output logic [DWIDTH-1:0]     Rdata_1,
  output logic                  Mem_En,
  output logic [AWIDTH-1:0]     Mem_Addr,
  output logic [3:0]            Mem_Wr_Ctrl,
  output logic [DWIDTH-1:0]     Mem_Wdata,
  input  logic [DWIDTH-1:0]     Mem_Rdata,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] Perf_Grant_0,
  output logic [PERF_CNT_W-1:0] Perf_Grant_1,
  output logic [PERF_CNT_W-1:0] Perf_Conflict,
`endif
  output logic                  Busy
);

  // WAIT lasts RD_LAT cycles: the counter runs RD_LAT-1 down to 0.
  localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [1:0]        req_vec, grant_oh;
  logic              winner, owner_q;
  logic              grant_en, take_grant;
  logic [AWIDTH-1:0] cmd_addr_q;
  logic [3:0]        cmd_wr_q;
  logic [DWIDTH-1:0] cmd_wdata_q;
  logic [3:0]        wait_cnt_q;
  logic [DWIDTH-1:0] rdata_0_q, rdata_1_q;

  assign req_vec    = {Req_1, Req_0};
  assign grant_en   = (state_q == IDLE);
  assign take_grant = grant_en && (|req_vec);

  rr_arb2 u_rr_arb2 (
    .clk_core   (Clk_Core),
    .rst_core_n (Rst_Core_N),
    .req        (req_vec),
    .grant_en   (grant_en),
    .grant      (grant_oh),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_vec) state_d = ISSUE;
      ISSUE:   state_d = (cmd_wr_q != WR_NONE) ? RESP : WAIT;
      WAIT:    if (wait_cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, read-latency counter and per-requester read data.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      owner_q     <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wr_q    <= WR_NONE;
      cmd_wdata_q <= '0;
      wait_cnt_q  <= 4'd0;
      rdata_0_q   <= '0;
      rdata_1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_grant) begin
            owner_q <= winner;
            if (grant_oh[REQ_1]) begin
              cmd_addr_q  <= Addr_1;
              cmd_wr_q    <= Wr_Ctrl_1;
              cmd_wdata_q <= Wdata_1;
            end else if (grant_oh[REQ_0]) begin
              cmd_addr_q  <= Addr_0;
              cmd_wr_q    <= Wr_Ctrl_0;
              cmd_wdata_q <= Wdata_0;
            end
          end
        end
        ISSUE: begin
          if (cmd_wr_q == WR_NONE) wait_cnt_q <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            if (owner_q) rdata_1_q <= Mem_Rdata;
            else         rdata_0_q <= Mem_Rdata;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory bus is quiet (all zero) outside ISSUE.
  always_comb begin
    Mem_En      = 1'b0;
    Mem_Addr    = '0;
    Mem_Wr_Ctrl = WR_NONE;
    Mem_Wdata   = '0;
    Ack_0       = 1'b0;
    Ack_1       = 1'b0;
    Busy        = (state_q != IDLE);
    Rdata_0     = rdata_0_q;
    Rdata_1     = rdata_1_q;
    case (state_q)
      ISSUE: begin
        Mem_En      = 1'b1;
        Mem_Addr    = cmd_addr_q;
        Mem_Wr_Ctrl = cmd_wr_q;
        Mem_Wdata   = cmd_wdata_q;
      end
      RESP: begin
        Ack_0 = (owner_q == 1'(REQ_0));
        Ack_1 = (owner_q == 1'(REQ_1));
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating grant and contention counters.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      Perf_Grant_0  <= '0;
      Perf_Grant_1  <= '0;
      Perf_Conflict <= '0;
    end else begin
      if (take_grant && grant_oh[REQ_0]) Perf_Grant_0  <= sat_inc(Perf_Grant_0);
      if (take_grant && grant_oh[REQ_1]) Perf_Grant_1  <= sat_inc(Perf_Grant_1);
      if (grant_en && Req_0 && Req_1)    Perf_Conflict <= sat_inc(Perf_Conflict);
    end
  end
`endif

endmodule
